// File: rtl/stream_rr_mux.sv
// N-channel valid/ready stream multiplexer with round-robin arbitration.
// A granted multi-beat packet holds the grant until its last beat, and the output stage is a single register.
module stream_rr_mux #(
    parameter int N_CH  = 4,
    parameter int WIDTH = 8,
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [N_CH-1:0]         i_valid,
    output logic [N_CH-1:0]         o_ready,
    input  logic [N_CH*WIDTH-1:0]   i_data,
    input  logic [N_CH-1:0]         i_last,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [WIDTH-1:0]        o_data,
    output logic                    o_last,
    output logic [CH_W-1:0]         o_ch
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    localparam logic [CH_W-1:0] PTR_RST = CH_W'(N_CH - 1);

    state_t            state_r;
    logic [CH_W-1:0]   ptr_r;
    logic [CH_W-1:0]   lock_ch_r;
    logic [CH_W-1:0]   grant_ch_s;
    logic              grant_found_s;
    logic [CH_W-1:0]   sel_ch_s;
    logic              sel_en_s;
    logic              load_s;
    logic              xfer_s;
    logic [N_CH-1:0]   ready_s;
    logic [WIDTH-1:0]  sel_data_s;

    // Modulo-N_CH offset from a channel index, so non-power-of-two counts never produce an index >= N_CH.
    function automatic logic [CH_W-1:0] wrap_add(input logic [CH_W-1:0] base, input int offset);
        return CH_W'((int'(base) + offset) % N_CH);
    endfunction

    // Rotating-priority search starting one past the last served channel.
    always_comb begin
        grant_found_s = 1'b0;
        grant_ch_s    = {CH_W{1'b0}};
        for (int i = 1; i <= N_CH; i++) begin
            if (!grant_found_s && i_valid[wrap_add(ptr_r, i)]) begin
                grant_found_s = 1'b1;
                grant_ch_s    = wrap_add(ptr_r, i);
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // Pick the single channel allowed to push this cycle and drive its ready.
    always_comb begin
        load_s   = !o_valid || i_ready;
        sel_ch_s = grant_ch_s;
        sel_en_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                sel_ch_s = grant_ch_s;
                sel_en_s = grant_found_s;
            end
            ST_LOCK: begin
                sel_ch_s = lock_ch_r;
                sel_en_s = 1'b1;
            end
            default: begin
                sel_ch_s = grant_ch_s;
                sel_en_s = 1'b0;
            end
        endcase
        ready_s = {N_CH{1'b0}};
        if (!i_rst && sel_en_s) begin
            ready_s[sel_ch_s] = load_s;
        end else begin
            ready_s = {N_CH{1'b0}};
        end
        xfer_s     = ready_s[sel_ch_s] && i_valid[sel_ch_s];
        sel_data_s = i_data[int'(sel_ch_s)*WIDTH +: WIDTH];
    end

    assign o_ready = ready_s;

    // Output register, arbitration pointer and packet lock; a held beat is simply not reloaded.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid   <= 1'b0;
            o_data    <= {WIDTH{1'b0}};
            o_last    <= 1'b0;
            o_ch      <= {CH_W{1'b0}};
            state_r   <= ST_IDLE;
            ptr_r     <= PTR_RST;
            lock_ch_r <= {CH_W{1'b0}};
        end else if (load_s) begin
            if (xfer_s) begin
                o_valid   <= 1'b1;
                o_data    <= sel_data_s;
                o_last    <= i_last[sel_ch_s];
                o_ch      <= sel_ch_s;
                ptr_r     <= sel_ch_s;
                lock_ch_r <= sel_ch_s;
                state_r   <= i_last[sel_ch_s] ? ST_IDLE : ST_LOCK;
            end else begin
                o_valid   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_rr_mux.sv
// Directed bench for stream_rr_mux: ordering, packet lock, backpressure,
// fairness, mid-packet reset and a 3-channel 16-bit instance.
module tb_stream_rr_mux;

    logic        clk;
    logic        rst;
    logic [3:0]  valid;
    logic [3:0]  ready;
    logic [31:0] data;
    logic [3:0]  last;
    logic        ovalid;
    logic        iready;
    logic [7:0]  odata;
    logic        olast;
    logic [1:0]  och;

    logic [2:0]  v2;
    logic [2:0]  rdy2;
    logic [47:0] d2;
    logic [2:0]  l2;
    logic        ovalid2;
    logic        iready2;
    logic [15:0] odata2;
    logic        olast2;
    logic [1:0]  och2;

    int vec_cnt;
    int miscompare_cnt;

    stream_rr_mux #(.N_CH(4), .WIDTH(8)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(ready),
        .i_data(data), .i_last(last), .o_valid(ovalid), .i_ready(iready),
        .o_data(odata), .o_last(olast), .o_ch(och)
    );

    stream_rr_mux #(.N_CH(3), .WIDTH(16)) dut3 (
        .i_clk(clk), .i_rst(rst), .i_valid(v2), .o_ready(rdy2),
        .i_data(d2), .i_last(l2), .o_valid(ovalid2), .i_ready(iready2),
        .o_data(odata2), .o_last(olast2), .o_ch(och2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            miscompare_cnt++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_cnt = 0;
        miscompare_cnt = 0;
        rst = 1'b1; valid = 4'h0; data = 32'h0; last = 4'h0; iready = 1'b1;
        v2 = 3'b000; d2 = 48'h0; l2 = 3'b000; iready2 = 1'b1;
        step();
        step();

        // reset state, ready forced low even with all valids up
        valid = 4'hF;
        #1;
        check_value("rst_ovalid", 32'(ovalid), 32'd0);
        check_value("rst_odata", 32'(odata), 32'd0);
        check_value("rst_olast", 32'(olast), 32'd0);
        check_value("rst_och", 32'(och), 32'd0);
        check_value("rst_ready", 32'(ready), 32'd0);

        // single-beat packets from every channel, channel 0 first
        rst = 1'b0;
        data = {8'h13, 8'h12, 8'h11, 8'h10};
        last = 4'hF;
        #1;
        check_value("t1_ovalid_pre", 32'(ovalid), 32'd0);
        for (int k = 0; k < 4; k++) begin
            check_value("t1_ready", 32'(ready), 32'd1 << k);
            step();
            check_value("t1_ovalid", 32'(ovalid), 32'd1);
            check_value("t1_odata", 32'(odata), 32'h10 + 32'(k));
            check_value("t1_och", 32'(och), 32'(k));
            valid[k] = 1'b0;
            #1;
        end
        check_value("t1_ready_idle", 32'(ready), 32'd0);
        step();
        check_value("t1_ovalid_end", 32'(ovalid), 32'd0);
        check_value("t1_odata_hold", 32'(odata), 32'h13);

        // 3-beat packet on ch1 must not be interleaved with ch2
        data = 32'h0;
        data[15:8] = 8'hA1;
        data[23:16] = 8'h20;
        last = 4'b0100;
        valid = 4'b0110;
        #1;
        check_value("t2_ready_b1", 32'(ready), 32'b0010);
        step();
        check_value("t2_odata_b1", 32'(odata), 32'hA1);
        check_value("t2_och_b1", 32'(och), 32'd1);
        check_value("t2_olast_b1", 32'(olast), 32'd0);
        data[15:8] = 8'hA2;
        #1;
        check_value("t2_ready_b2", 32'(ready), 32'b0010);
        step();
        check_value("t2_odata_b2", 32'(odata), 32'hA2);
        check_value("t2_och_b2", 32'(och), 32'd1);
        data[15:8] = 8'hA3;
        last[1] = 1'b1;
        #1;
        check_value("t2_ready_b3", 32'(ready), 32'b0010);
        step();
        check_value("t2_odata_b3", 32'(odata), 32'hA3);
        check_value("t2_och_b3", 32'(och), 32'd1);
        check_value("t2_olast_b3", 32'(olast), 32'd1);
        valid[1] = 1'b0;
        #1;
        check_value("t2_ready_ch2", 32'(ready), 32'b0100);
        step();
        check_value("t2_odata_ch2", 32'(odata), 32'h20);
        check_value("t2_och_ch2", 32'(och), 32'd2);
        valid = 4'h0;
        step();
        check_value("t2_ovalid_end", 32'(ovalid), 32'd0);

        // backpressure holds 0x55 for three cycles, then 0x66 follows once
        data = 32'h0;
        data[31:24] = 8'h55;
        data[7:0] = 8'h66;
        last = 4'hF;
        valid = 4'b1001;
        #1;
        check_value("t3_ready_first", 32'(ready), 32'b1000);
        step();
        check_value("t3_odata_load", 32'(odata), 32'h55);
        check_value("t3_och_load", 32'(och), 32'd3);
        valid[3] = 1'b0;
        iready = 1'b0;
        #1;
        check_value("t3_ready_stall", 32'(ready), 32'd0);
        for (int c = 0; c < 3; c++) begin
            step();
            check_value("t3_ovalid_hold", 32'(ovalid), 32'd1);
            check_value("t3_odata_hold", 32'(odata), 32'h55);
            check_value("t3_och_hold", 32'(och), 32'd3);
            check_value("t3_ready_hold", 32'(ready), 32'd0);
        end
        iready = 1'b1;
        #1;
        check_value("t3_ready_resume", 32'(ready), 32'b0001);
        step();
        check_value("t3_odata_next", 32'(odata), 32'h66);
        check_value("t3_och_next", 32'(och), 32'd0);
        valid = 4'h0;
        step();
        check_value("t3_ovalid_end", 32'(ovalid), 32'd0);

        // fairness: all channels continuously valid, 12 beats
        rst = 1'b1;
        step();
        rst = 1'b0;
        data = {8'h33, 8'h32, 8'h31, 8'h30};
        last = 4'hF;
        valid = 4'hF;
        #1;
        for (int i = 0; i < 12; i++) begin
            check_value("t4_ready", 32'(ready), 32'd1 << (i % 4));
            step();
            check_value("t4_och", 32'(och), 32'(i % 4));
            check_value("t4_odata", 32'(odata), 32'h30 + 32'(i % 4));
        end
        valid = 4'h0;
        step();
        check_value("t4_ovalid_end", 32'(ovalid), 32'd0);

        // reset in the middle of a ch3 packet drops the lock and the held beat
        data = 32'h0;
        data[31:24] = 8'h70;
        last = 4'h0;
        valid = 4'b1000;
        #1;
        check_value("t5_ready_b1", 32'(ready), 32'b1000);
        step();
        check_value("t5_odata_b1", 32'(odata), 32'h70);
        check_value("t5_olast_b1", 32'(olast), 32'd0);
        data[31:24] = 8'h71;
        #1;
        check_value("t5_ready_b2", 32'(ready), 32'b1000);
        step();
        check_value("t5_odata_b2", 32'(odata), 32'h71);
        rst = 1'b1;
        valid = 4'b1001;
        data[7:0] = 8'h80;
        last = 4'b0001;
        #1;
        check_value("t5_ready_in_rst", 32'(ready), 32'd0);
        step();
        check_value("t5_ovalid_rst", 32'(ovalid), 32'd0);
        check_value("t5_ready_rst", 32'(ready), 32'd0);
        rst = 1'b0;
        #1;
        check_value("t5_ready_after", 32'(ready), 32'b0001);
        step();
        check_value("t5_ovalid_after", 32'(ovalid), 32'd1);
        check_value("t5_och_after", 32'(och), 32'd0);
        check_value("t5_odata_after", 32'(odata), 32'h80);
        valid = 4'h0;
        step();

        // 3-channel 16-bit instance alternates between channels 0 and 2
        d2 = {16'h2002, 16'h0000, 16'h1000};
        l2 = 3'b111;
        v2 = 3'b101;
        #1;
        for (int i = 0; i < 4; i++) begin
            check_value("t6_ready", 32'(rdy2), ((i % 2) == 1) ? 32'b100 : 32'b001);
            step();
            check_value("t6_ovalid", 32'(ovalid2), 32'd1);
            check_value("t6_och", 32'(och2), ((i % 2) == 1) ? 32'd2 : 32'd0);
            check_value("t6_odata", 32'(odata2), ((i % 2) == 1) ? 32'h2002 : 32'h1000);
        end
        v2 = 3'b000;
        step();
        check_value("t6_ovalid_end", 32'(ovalid2), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompare_cnt);
        $finish;
    end

endmodule
